// File: rtl/nn_pkg.sv
// Package: nn_pkg
// Shared definitions for the neural-network compute slice:
//   - default fixed-point geometry (INT_WIDTH_DEF / FRAC_WIDTH_DEF) and word type fixed_t
//   - mac_state_t : sequencer state encoding shared by neuron-level sequencers
//   - saturate()  : clamp a wide signed value into a w-bit signed range
package nn_pkg;

  localparam int unsigned INT_WIDTH_DEF  = 8;
  localparam int unsigned FRAC_WIDTH_DEF = 8;
  localparam int unsigned SAT_W          = 64;

  typedef logic signed [INT_WIDTH_DEF-1:-FRAC_WIDTH_DEF] fixed_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISH
  } mac_state_t;

  // Clamp v into [-(2^(w-1)), 2^(w-1)-1]; the caller narrows the result to w bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (v > max_v)      return max_v;
    else if (v < min_v) return min_v;
    else                return v;
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Module: mac_accumulator
// Signed multiply-accumulate: acc <= acc + a*b when enable, acc <= 0 when clear.
// The product is kept at full precision (2*W bits) before being sign-extended into acc.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   clear          zero the accumulator (has priority over enable)
//   enable         add a*b this cycle
//   a, b           signed W-bit operands
//   acc            signed ACC_W-bit running sum
module mac_accumulator #(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 35
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] product;

  assign a_ext   = PW'(a);
  assign b_ext   = PW'(b);
  assign product = a_ext * b_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(product);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Module: neuron_mac
// Single-neuron compute stage fed by a per-neuron weight rom (1 cycle read latency).
// On start it walks rom addresses 0..NUM_INPUTS-1, multiplies each returned weight by
// the matching input, accumulates, adds the bias, saturates and registers one result.
// Latency start->done is NUM_INPUTS+2 clock edges.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   start            begin one evaluation (sampled in IDLE only)
//   inputs           input vector, held stable while busy
//   bias             bias, captured on the start edge
//   weight_enable    rom read enable
//   weight_address   rom address
//   weight           rom data, valid one cycle after enable/address
//   out              saturated result, held until the next done
//   busy             high from the start edge until the done edge
//   done             one-cycle pulse when out updates
// Build option: NEURON_MAC_RELU_EN forces negative saturated results to zero.
module neuron_mac
  import nn_pkg::*;
#(
  parameter  int unsigned INT_WIDTH  = INT_WIDTH_DEF,
  parameter  int unsigned FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter  int unsigned NUM_INPUTS = 4,
  localparam int unsigned AW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic signed [INT_WIDTH-1:-FRAC_WIDTH]  inputs [NUM_INPUTS],
  input  logic signed [INT_WIDTH-1:-FRAC_WIDTH]  bias,
  output logic                                   weight_enable,
  output logic        [AW-1:0]                   weight_address,
  input  logic signed [INT_WIDTH-1:-FRAC_WIDTH]  weight,
  output logic signed [INT_WIDTH-1:-FRAC_WIDTH]  out,
  output logic                                   busy,
  output logic                                   done
);

  localparam int unsigned W         = INT_WIDTH + FRAC_WIDTH;
  localparam int unsigned ACC_W     = 2 * W + $clog2(NUM_INPUTS) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUTS - 1);

  mac_state_t state, state_next;
  logic                          load;
  logic                          finish;
  logic                          valid_d;
  logic [AW-1:0]                 idx_d;
  logic signed [W-1:0]           bias_q;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       bias_ext;
  logic signed [ACC_W-1:0]       sum;
  logic signed [ACC_W-1:0]       shifted;
  logic signed [W-1:0]           sat;
  logic signed [W-1:0]           result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          load       = 1'b1;
        end
      end
      ST_FETCH: begin
        if (weight_address == LAST_ADDR) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last product lands in acc on the edge that leaves DRAIN.
        if (valid_d && (idx_d == LAST_ADDR)) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
        finish     = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      weight_enable  <= 1'b0;
      weight_address <= '0;
      valid_d        <= 1'b0;
      idx_d          <= '0;
      bias_q         <= '0;
      out            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      // Rom data returns one cycle after the request; delay the request to align.
      valid_d <= weight_enable;
      idx_d   <= weight_address;
      done    <= finish;
      if (load) begin
        busy           <= 1'b1;
        weight_enable  <= 1'b1;
        weight_address <= '0;
        bias_q         <= bias;
      end else if (state == ST_FETCH) begin
        if (weight_address == LAST_ADDR) weight_enable  <= 1'b0;
        else                             weight_address <= weight_address + AW'(1);
      end
      if (finish) begin
        out  <= result;
        busy <= 1'b0;
      end
    end
  end

  mac_accumulator #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .enable (valid_d),
    .a      (weight),
    .b      (inputs[idx_d]),
    .acc    (acc)
  );

  // Bias is aligned to the 2*FRAC_WIDTH product scale before the final rescale.
  assign bias_ext = ACC_W'(bias_q) <<< FRAC_WIDTH;
  assign sum      = acc + bias_ext;
  assign shifted  = sum >>> FRAC_WIDTH;
  assign sat      = W'(saturate(SAT_W'(shifted), W));

`ifdef NEURON_MAC_RELU_EN
  assign result = sat[W-1] ? '0 : sat;
`else
  assign result = sat;
`endif

endmodule

// File: tb/tb_neuron_mac.sv
`timescale 1ns/1ps
module tb_neuron_mac;
  import nn_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  fixed_t      inputs [4];
  fixed_t      bias;
  logic        weight_enable;
  logic [1:0]  weight_address;
  fixed_t      weight;
  fixed_t      out;
  logic        busy;
  logic        done;

  logic        start1 = 1'b0;
  fixed_t      inputs1 [1];
  fixed_t      bias1;
  logic        weight_enable1;
  logic [0:0]  weight_address1;
  fixed_t      weight1;
  fixed_t      out1;
  logic        busy1;
  logic        done1;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  // 1.0, 0.5, -1.0, 2.0
  fixed_t rom [4] = '{16'h0100, 16'h0080, 16'hFF00, 16'h0200};

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (weight_enable)  weight  <= rom[weight_address];
    if (weight_enable1) weight1 <= 16'h0180;  // 1.5
  end

  neuron_mac #(.NUM_INPUTS(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .inputs         (inputs),
    .bias           (bias),
    .weight_enable  (weight_enable),
    .weight_address (weight_address),
    .weight         (weight),
    .out            (out),
    .busy           (busy),
    .done           (done)
  );

  neuron_mac #(.NUM_INPUTS(1)) dut1 (
    .clock          (clock),
    .reset          (reset),
    .start          (start1),
    .inputs         (inputs1),
    .bias           (bias1),
    .weight_enable  (weight_enable1),
    .weight_address (weight_address1),
    .weight         (weight1),
    .out            (out1),
    .busy           (busy1),
    .done           (done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: single start pulse; 1: extra pulses before edges 2 and 5;
  // 2: start held through edge 13 for two back-to-back evaluations.
  task automatic run_eval(input string tag, input fixed_t exp_out, input int unsigned mode);
    int unsigned en_cycles;
    int unsigned done_cnt;
    int unsigned first_done;
    int unsigned second_done;
    en_cycles = 0; done_cnt = 0; first_done = 0; second_done = 0;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    check({tag, " busy@0"}, 32'(busy), 32'd1);
    check({tag, " addr@0"}, 32'(weight_address), 32'd0);
    if (weight_enable) en_cycles++;
    for (int unsigned i = 1; i <= 20; i++) begin
      @(negedge clock);
      case (mode)
        1:       start = (i == 2) || (i == 5);
        2:       start = (i <= 13);
        default: start = 1'b0;
      endcase
      @(posedge clock); #1;
      if (i <= 3) check($sformatf("%s addr@%0d", tag, i), 32'(weight_address), 32'(i));
      if (weight_enable && i < 7) en_cycles++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = i;
        else               second_done = i;
        check({tag, " out@done"}, out, exp_out);
      end
    end
    start = 1'b0;
    check({tag, " en_cycles"}, en_cycles, 32'd4);
    check({tag, " done_edge"}, first_done, 32'd6);
    check({tag, " done_count"}, done_cnt, (mode == 2) ? 32'd2 : 32'd1);
    if (mode == 2) check({tag, " done2_edge"}, second_done, 32'd13);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " out_held"}, out, exp_out);
  endtask

  initial begin
    int unsigned n1_done;
    fixed_t exp_neg;
    inputs  = '{16'h0200, 16'h0400, 16'h0100, 16'h0080};
    bias    = 16'h0040;
    inputs1 = '{16'h0200};
    bias1   = 16'h0010;

    repeat (2) @(posedge clock);
    #1;
    check("rst out",  out, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst en",   32'(weight_enable), 32'd0);
    check("rst addr", 32'(weight_address), 32'd0);
    @(negedge clock); reset = 1'b0;

    // 2*1 + 4*0.5 + 1*(-1) + 0.5*2 + 0.25 = 4.25
    run_eval("nominal", 16'h0440, 0);

    inputs = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    bias   = 16'h0000;
    run_eval("saturate", 16'h7FFF, 0);

    // 4*(-1) + 0.25 = -3.75
    inputs = '{16'h0000, 16'h0000, 16'h0400, 16'h0000};
    bias   = 16'h0040;
`ifdef NEURON_MAC_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'hFC40;
`endif
    run_eval("negative", exp_neg, 0);

    inputs = '{16'h0200, 16'h0400, 16'h0100, 16'h0080};
    run_eval("extra_start", 16'h0440, 1);
    run_eval("back2back", 16'h0440, 2);

    // Reset in the middle of a run.
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #1; reset = 1'b1;
    #1;
    check("midrst out",  out, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst en",   32'(weight_enable), 32'd0);
    check("midrst addr", 32'(weight_address), 32'd0);
    @(negedge clock); reset = 1'b0;
    run_eval("rerun", 16'h0440, 0);

    // Single-input neuron: 2.0*1.5 + 0.0625 = 3.0625, done at edge 3.
    n1_done = 0;
    @(negedge clock); start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (done1 && n1_done == 0) n1_done = i;
    end
    check("n1 done_edge", n1_done, 32'd3);
    check("n1 out", out1, 32'h0310);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
